stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Control stage directly upstream of the 4-digit BCD stopwatch counter/display path.
//   - Debounces two board push-buttons (START/STOP, LAP/RESET).
//   - Runs the run/pause/lap state machine.
//   - Produces the gated 0.1 s count tick, a synchronous counter-clear pulse and a
//     display-freeze level. The counter consumes tick_o/clear_o; the display mux consumes freeze_o.
// PARAMETERS
//   FPGA_FREQ    50_000_000  clk_i frequency in Hz
//   DEBOUNCE_MS  20          button stable time in ms; DEB_CYC = FPGA_FREQ/1000*DEBOUNCE_MS
//   TICK_HZ      10          count tick rate; DIV = FPGA_FREQ/TICK_HZ
// PORTS
//   clk_i          in   1  single system clock
//   rst_n_i        in   1  asynchronous reset, active-low
//   btn_start_n_i  in   1  START/STOP button, raw, asynchronous, active-low
//   btn_lap_n_i    in   1  LAP/RESET button, raw, asynchronous, active-low
//   tick_o         out  1  1-cycle pulse every DIV cycles while counting
//   clear_o        out  1  1-cycle pulse: counter returns to 0
//   freeze_o       out  1  level: display holds its last value (lap view)
//   running_o      out  1  level: counting active (state RUN or LAP)
//   state_o        out  2  current state encoding, for debug and LEDs
// BEHAVIOUR
//   Reset: state IDLE, prescaler 0, debouncers at released level, all outputs 0.
//     Reset mid-operation aborts everything with no residual pulse.
//   Debounce (per button):
//     - 2-FF synchroniser.
//     - Stability counter restarts on every change of the synchronised sample.
//     - Debounced level takes the new value once the sample has been stable DEB_CYC cycles.
//     - Press event = 1-cycle pulse on the released->pressed transition of the debounced level.
//       Release events are ignored.
//   FSM (registered; transitions on press events; outputs valid the cycle after the event):
//     IDLE(00)  start -> RUN, clear prescaler;  lap -> stay IDLE, pulse clear_o
//     RUN(01)   start -> PAUSE;  lap -> LAP (freeze_o=1)
//     LAP(11)   lap -> RUN (freeze_o=0);  start -> PAUSE (freeze_o=0)
//     PAUSE(10) start -> RUN;  lap -> IDLE, pulse clear_o, prescaler <= 0
//   Simultaneous start and lap events in the same cycle: start wins, lap is discarded.
//   Prescaler (width $clog2(DIV)):
//     - Counts 0..DIV-1 only in RUN/LAP.
//     - tick_o=1 in the cycle the prescaler wraps from DIV-1 to 0.
//     - Holds its value in PAUSE, so resuming continues the partial interval (no lost time).
//     - Zeroed on IDLE->RUN and on any clear_o.
//   No tick_o during IDLE/PAUSE.
//   clear_o and tick_o are never high in the same cycle.
//   freeze_o=1 only in LAP; running_o = (state==RUN || state==LAP).
// STRUCTURE
//   Package stopwatch_pkg:
//     - state_t enum {IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11}
//     - function computing DEB_CYC and DIV from the parameters
//   Sub-module button_debounce (params FPGA_FREQ, DEBOUNCE_MS; ports clk_i, rst_n_i,
//     btn_n_i, pressed_o, press_o), instantiated twice.
//   Top level holds the FSM, the prescaler and the output registers.
// TESTING  (bench params: FPGA_FREQ=1000, DEBOUNCE_MS=4 -> DEB_CYC=4; TICK_HZ=100 -> DIV=10)
//   1. Reset, no presses for 100 cycles -> tick_o, clear_o, freeze_o, running_o all 0; state_o=00.
//   2. start held low 20 cycles -> one press event; running_o=1; tick_o every 10 cycles,
//      first tick 10 cycles after entering RUN.
//   3. start bouncing (toggle every 2 cycles for 12 cycles, then low) -> exactly one
//      transition, only after 4 stable cycles.
//   4. RUN, pause after 6 prescaler counts, resume -> first tick 4 cycles after re-entering
//      RUN; no tick in PAUSE.
//   5. RUN -> lap -> freeze_o=1, ticks continue; lap again -> freeze_o=0, state RUN.
//   6. PAUSE -> lap -> one clear_o pulse, state IDLE. Start+lap events in the same cycle
//      from IDLE -> RUN with no clear_o. Assert rst_n_i mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and parameter helpers for the stopwatch control stage.
package stopwatch_pkg;

   // State encoding is visible on state_o, so the values are fixed.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } state_t;

   // Cycles a button sample must stay unchanged before the debounced level follows it.
   function automatic int unsigned deb_cycles(input int unsigned freq, input int unsigned ms);
      int unsigned c;
      c = freq / 1000 * ms;
      return (c == 0) ? 1 : c;
   endfunction

   // Clock cycles per count tick.
   function automatic int unsigned div_cycles(input int unsigned freq, input int unsigned hz);
      int unsigned c;
      c = freq / hz;
      return (c == 0) ? 1 : c;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the board buttons, the control stage and the counter/display path.
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic   btn_start_n_i;   // raw START/STOP, active-low
   logic   btn_lap_n_i;     // raw LAP/RESET, active-low
   logic   tick_o;          // gated count tick
   logic   clear_o;         // counter clear pulse
   logic   freeze_o;        // display hold (lap view)
   logic   running_o;       // counting active
   state_t state_o;         // current state, for LEDs
   logic   start_pressed;   // debounced START level, for LEDs
   logic   lap_pressed;     // debounced LAP level, for LEDs

   // The control stage drives the outputs and reads the buttons.
   modport master (
      input  btn_start_n_i, btn_lap_n_i,
      output tick_o, clear_o, freeze_o, running_o, state_o, start_pressed, lap_pressed
   );

   // The board side drives the buttons and consumes the outputs.
   modport slave (
      output btn_start_n_i, btn_lap_n_i,
      input  tick_o, clear_o, freeze_o, running_o, state_o, start_pressed, lap_pressed
   );

endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability filter and press-edge detector.
module button_debounce
   import stopwatch_pkg::*;
#(
   parameter int unsigned FPGA_FREQ   = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 20
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic btn_n_i,
   output logic pressed_o,
   output logic press_o
);

   localparam int unsigned DEB_CYC = deb_cycles(FPGA_FREQ, DEBOUNCE_MS);
   localparam int unsigned CNT_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   logic             sync1_n;
   logic             sync2_n;
   logic             level_n;
   logic [CNT_W-1:0] stable_cnt;

   // Synchronise, count consecutive samples that differ from the level, flip after DEB_CYC of them.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: the synchroniser resets to the released level so no phantom press follows reset.
         sync1_n    <= 1'b1;
         sync2_n    <= 1'b1;
         level_n    <= 1'b1;
         stable_cnt <= '0;
         press_o    <= 1'b0;
      end else begin
         // NOTE: non-blocking here so sync2_n takes the old sync1_n, giving a true two-stage chain.
         sync1_n <= btn_n_i;
         sync2_n <= sync1_n;
         press_o <= 1'b0;
         if (sync2_n == level_n) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_W'(DEB_CYC - 1)) begin
            level_n    <= sync2_n;
            stable_cnt <= '0;
            press_o    <= ~sync2_n;   // only released->pressed produces an event
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

   assign pressed_o = ~level_n;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: button conditioning, run/pause/lap FSM, tick prescaler.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned FPGA_FREQ   = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned TICK_HZ     = 10
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   stopwatch_ctrl_if.master sw
);

   localparam int unsigned DIV   = div_cycles(FPGA_FREQ, TICK_HZ);
   localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic             start_ev;
   logic             lap_raw_ev;
   logic             lap_ev;
   state_t           state_q;
   state_t           state_d;
   logic             clear_d;
   logic             pre_zero;
   logic             counting;
   logic [PRE_W-1:0] pre_q;
   logic             tick_q;
   logic             clear_q;

   button_debounce #(.FPGA_FREQ(FPGA_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_start_deb (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .btn_n_i   (sw.btn_start_n_i),
      .pressed_o (sw.start_pressed),
      .press_o   (start_ev)
   );

   button_debounce #(.FPGA_FREQ(FPGA_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_lap_deb (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .btn_n_i   (sw.btn_lap_n_i),
      .pressed_o (sw.lap_pressed),
      .press_o   (lap_raw_ev)
   );

   // A coincident start event takes priority; the lap event is dropped.
   assign lap_ev   = lap_raw_ev & ~start_ev;
   assign counting = (state_q == RUN) || (state_q == LAP);

   // Next-state decode plus the clear / prescaler-zero requests of each transition.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      state_d  = state_q;
      clear_d  = 1'b0;
      pre_zero = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_ev) begin
               state_d  = RUN;
               pre_zero = 1'b1;
            end else if (lap_ev) begin
               clear_d  = 1'b1;
               pre_zero = 1'b1;
            end
         end
         RUN: begin
            if (start_ev)    state_d = PAUSE;
            else if (lap_ev) state_d = LAP;
         end
         LAP: begin
            if (start_ev)    state_d = PAUSE;
            else if (lap_ev) state_d = RUN;
         end
         PAUSE: begin
            if (start_ev) begin
               state_d = RUN;
            end else if (lap_ev) begin
               state_d  = IDLE;
               clear_d  = 1'b1;
               pre_zero = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Prescaler and output pulses; zeroing only happens in IDLE/PAUSE, so it never races a tick.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pre_q   <= '0;
         tick_q  <= 1'b0;
         clear_q <= 1'b0;
      end else begin
         tick_q  <= 1'b0;
         clear_q <= clear_d;
         if (pre_zero) begin
            pre_q <= '0;
         end else if (counting) begin
            if (pre_q == PRE_W'(DIV - 1)) begin
               pre_q  <= '0;
               tick_q <= 1'b1;
            end else begin
               pre_q <= pre_q + 1'b1;
            end
         end
      end
   end

   assign sw.tick_o    = tick_q;
   assign sw.clear_o   = clear_q;
   assign sw.state_o   = state_q;
   assign sw.freeze_o  = (state_q == LAP);
   assign sw.running_o = counting;

endmodule
